// File: rtl/leg_pkg.sv
// leg_pkg: shared types and constants for the LEGv8 instruction encoder.
// Contents: op_t operation enum, opcode field constants, immediate field widths,
//           and a helper that tests whether a 64-bit value fits a signed field.
package leg_pkg;

  // Operation codes on in_op. Values 8..15 are not defined and encode as errors.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    ORR  = 4'd3,
    LDUR = 4'd4,
    STUR = 4'd5,
    CBZ  = 4'd6,
    MOVZ = 4'd7
  } op_t;

  // Opcode fields, MSB-aligned at bit 31 of the instruction word.
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_AND   = 11'b10001010000;
  localparam logic [10:0] OPC_ORR   = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ8  = 8'b10110100;
  localparam logic [8:0]  OPC_MOVZ9 = 9'b110100101;

  // Immediate field widths. DT and COND_BR fields are signed.
  localparam int DT_W    = 9;   // DT_address, -256..255
  localparam int CB_W    = 19;  // COND_BR_address, -2^18..2^18-1
  localparam int IMM16_W = 16;  // MOVZ imm16
  localparam int PACK_W  = 19;  // widest packed immediate

  // True when v is the sign extension of its low w bits, i.e. bits [63:w-1]
  // are all zero or all one.
  function automatic logic sext_fits(input logic [63:0] v, input int w);
    logic [63:0] m;
    m = ~64'd0 << (w - 1);
    return ((v & m) == 64'd0) || ((v & m) == m);
  endfunction

endpackage

// File: rtl/leg_imm_pack.sv
// leg_imm_pack: combinational immediate range check and packing per operation.
// Ports: op_i/imm_i in; imm_bits_o (packed field, LSB-aligned), hw_o (MOVZ shift), range_err_o out.
// Latency 0 (pure combinational); no flow control.
module leg_imm_pack
  import leg_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [63:0]       imm_i,
  output logic [PACK_W-1:0] imm_bits_o,
  output logic [1:0]        hw_o,
  output logic              range_err_o
);

  logic [3:0] nz;  // which 16-bit chunks of imm_i are non-zero

  always_comb begin
    for (int h = 0; h < 4; h++) begin
      nz[h] = |imm_i[16*h +: 16];
    end
  end

  always_comb begin
    imm_bits_o  = '0;
    hw_o        = 2'd0;
    range_err_o = 1'b0;
    case (op_i)
      LDUR, STUR: begin
        imm_bits_o  = {{(PACK_W-DT_W){1'b0}}, imm_i[DT_W-1:0]};
        range_err_o = !sext_fits(imm_i, DT_W);
      end
      CBZ: begin
        imm_bits_o  = imm_i[CB_W-1:0];
        range_err_o = !sext_fits(imm_i, CB_W);
      end
      MOVZ: begin
        // Exactly one non-zero chunk selects hw; an all-zero value encodes hw=0.
        case (nz)
          4'b0000, 4'b0001: begin
            hw_o = 2'd0; imm_bits_o = {{(PACK_W-IMM16_W){1'b0}}, imm_i[15:0]};
          end
          4'b0010: begin
            hw_o = 2'd1; imm_bits_o = {{(PACK_W-IMM16_W){1'b0}}, imm_i[31:16]};
          end
          4'b0100: begin
            hw_o = 2'd2; imm_bits_o = {{(PACK_W-IMM16_W){1'b0}}, imm_i[47:32]};
          end
          4'b1000: begin
            hw_o = 2'd3; imm_bits_o = {{(PACK_W-IMM16_W){1'b0}}, imm_i[63:48]};
          end
          default: range_err_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/leg_instr_encoder.sv
// leg_instr_encoder: streams decoded LEGv8 fields in, packed 32-bit words + byte address out.
// Ports: clk/reset/restart; in_valid/in_ready/in_op/in_rd/in_rn/in_rm/in_imm;
//        out_valid/out_ready/out_instr/out_addr/out_err; err_count.
// Latency 2 cycles (S1 fields, S2 encoded word), 1 word/cycle.
// Backpressure: S2 holds while out_ready=0; in_ready is combinational from out_ready.
module leg_instr_encoder
  import leg_pkg::*;
#(
  parameter int             AW   = 8,
  parameter logic [AW-1:0]  BASE = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [63:0]   in_imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic          out_err,
  output logic [7:0]    err_count
);

  // S1: registered input fields
  logic        s1_vld_q;
  logic [3:0]  s1_op_q;
  logic [4:0]  s1_rd_q, s1_rn_q, s1_rm_q;
  logic [63:0] s1_imm_q;

  // S2: registered encoded word
  logic        s2_vld_q;
  logic [31:0] s2_instr_q;
  logic        s2_err_q;

  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [31:0]       instr_d;
  logic              err_d;
  logic [PACK_W-1:0] pk_bits;
  logic [1:0]        pk_hw;
  logic              pk_range_err;

  logic s2_adv, s1_adv, out_hs;

  assign s2_adv = !s2_vld_q || out_ready;
  assign s1_adv = !s1_vld_q || s2_adv;
  assign out_hs = s2_vld_q && out_ready;

  leg_imm_pack u_imm_pack (
    .op_i        (s1_op_q),
    .imm_i       (s1_imm_q),
    .imm_bits_o  (pk_bits),
    .hw_o        (pk_hw),
    .range_err_o (pk_range_err)
  );

  always_comb begin
    instr_d = 32'h0;
    err_d   = 1'b0;
    case (s1_op_q)
      ADD:  instr_d = {OPC_ADD, s1_rm_q, 6'd0, s1_rn_q, s1_rd_q};
      SUB:  instr_d = {OPC_SUB, s1_rm_q, 6'd0, s1_rn_q, s1_rd_q};
      AND:  instr_d = {OPC_AND, s1_rm_q, 6'd0, s1_rn_q, s1_rd_q};
      ORR:  instr_d = {OPC_ORR, s1_rm_q, 6'd0, s1_rn_q, s1_rd_q};
      LDUR: instr_d = {OPC_LDUR, pk_bits[DT_W-1:0], 2'b00, s1_rn_q, s1_rd_q};
      STUR: instr_d = {OPC_STUR, pk_bits[DT_W-1:0], 2'b00, s1_rn_q, s1_rd_q};
      CBZ:  instr_d = {OPC_CBZ8, pk_bits[CB_W-1:0], s1_rd_q};
      MOVZ: instr_d = {OPC_MOVZ9, pk_hw, pk_bits[IMM16_W-1:0], s1_rd_q};
      default: err_d = 1'b1;
    endcase
    // An errored word is still delivered, but with a zero payload.
    if (pk_range_err) begin
      instr_d = 32'h0;
      err_d   = 1'b1;
    end
  end

  // Address belongs to whatever word sits in S2, so it only moves on a
  // handshake; restart overrides an in-flight advance.
  always_comb begin
    addr_d = addr_q;
    if (restart)     addr_d = BASE;
    else if (out_hs) addr_d = addr_q + AW'(4);
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_hs && s2_err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_op_q    <= 4'd0;
      s1_rd_q    <= 5'd0;
      s1_rn_q    <= 5'd0;
      s1_rm_q    <= 5'd0;
      s1_imm_q   <= 64'd0;
      s2_vld_q   <= 1'b0;
      s2_instr_q <= 32'h0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE;
      err_cnt_q  <= 8'd0;
    end else begin
      if (s1_adv) begin
        s1_vld_q <= in_valid;
        if (in_valid) begin
          s1_op_q  <= in_op;
          s1_rd_q  <= in_rd;
          s1_rn_q  <= in_rn;
          s1_rm_q  <= in_rm;
          s1_imm_q <= in_imm;
        end
      end
      if (s2_adv) begin
        s2_vld_q   <= s1_vld_q;
        s2_instr_q <= s1_vld_q ? instr_d : 32'h0;
        s2_err_q   <= s1_vld_q && err_d;
      end
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = s2_vld_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign out_addr  = addr_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_leg_instr_encoder.sv
// tb_leg_instr_encoder: scoreboard bench for leg_instr_encoder (AW=8, BASE=0x40)
// plus an AW=4 twin sharing the same stimulus to observe address wrap.
module tb_leg_instr_encoder;

  localparam logic [7:0] BASE_A = 8'h40;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, out_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [63:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [7:0]  out_addr, err_count;
  logic        in_ready4, out_valid4, out_err4;
  logic [31:0] out_instr4;
  logic [3:0]  out_addr4;
  logic [7:0]  err_count4;

  always #5 clk = ~clk;

  leg_instr_encoder #(.AW(8), .BASE(BASE_A)) u_dut (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  leg_instr_encoder #(.AW(4), .BASE(4'h0)) u_dut4 (
    .clk(clk), .reset(reset), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready4), .in_op(in_op),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
    .out_addr(out_addr4), .out_err(out_err4), .err_count(err_count4)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  logic [31:0] cur_instr;
  logic        cur_err;
  bit          cur_lat;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [7:0]  m_addr;
  logic [3:0]  m_addr4;
  int          m_errs;
  bit          rand_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference encoder, written from the instruction formats.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rn, input logic [4:0] rm,
                                        input logic [63:0] imm);
    longint      s;
    logic [31:0] w;
    logic        er;
    int          hits;
    int          hw;
    s = imm; w = 32'h0; er = 1'b0; hits = 0; hw = 0;
    case (op)
      4'd0: w = {11'b10001011000, rm, 6'd0, rn, rd};
      4'd1: w = {11'b11001011000, rm, 6'd0, rn, rd};
      4'd2: w = {11'b10001010000, rm, 6'd0, rn, rd};
      4'd3: w = {11'b10101010000, rm, 6'd0, rn, rd};
      4'd4, 4'd5: begin
        if (s < -256 || s > 255) er = 1'b1;
        else w = {((op == 4'd4) ? 11'b11111000010 : 11'b11111000000), imm[8:0], 2'b00, rn, rd};
      end
      4'd6: begin
        if (s < -262144 || s > 262143) er = 1'b1;
        else w = {8'b10110100, imm[18:0], rd};
      end
      4'd7: begin
        if (imm == 64'd0) w = {9'b110100101, 2'd0, 16'd0, rd};
        else begin
          for (int h = 0; h < 4; h++) begin
            if (imm == ({48'd0, imm[16*h +: 16]} << (16*h))) begin
              hits++;
              hw = h;
            end
          end
          if (hits == 1) w = {9'b110100101, 2'(hw), imm[16*hw +: 16], rd};
          else er = 1'b1;
        end
      end
      default: er = 1'b1;
    endcase
    if (er) w = 32'h0;
    return {er, w};
  endfunction

  // Monitor: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      m_addr  = BASE_A;
      m_addr4 = 4'h0;
      m_errs  = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("spurious_word", out_valid, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("instr", out_instr, e.instr);
          chk("err", out_err, e.err);
          if (e.lat) chk("latency", cyc - e.cyc, 2);
          chk("addr", out_addr, m_addr);
          chk("addr_aw4", out_addr4, m_addr4);
          chk("err_count", err_count, m_errs);
          if (e.err && m_errs < 255) m_errs++;
        end
        m_addr  = m_addr + 8'd4;
        m_addr4 = m_addr4 + 4'd4;
      end
      if (restart) begin
        m_addr  = BASE_A;
        m_addr4 = 4'h0;
      end
      if (in_valid && in_ready) sbq.push_back('{cur_instr, cur_err, cyc, cur_lat});
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                      input logic [4:0] rm, input logic [63:0] imm,
                      input logic [31:0] x_instr, input logic x_err, input bit lat = 0);
    bit acc;
    in_op = op; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm;
    cur_instr = x_instr; cur_err = x_err; cur_lat = lat;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [63:0] imm);
    logic [32:0] r;
    r = model(op, rd, rn, rm, imm);
    send(op, rd, rn, rm, imm, r[31:0], r[32]);
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sbq.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] imm;
    longint      t;
    logic [32:0] r1;
    reset = 1'b1; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 4'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 64'd0;
    cur_instr = 32'h0; cur_err = 1'b0; cur_lat = 0;
    step(); step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_addr", out_addr, BASE_A);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    step();

    // Directed vectors, consumer always ready.
    out_ready = 1'b1;
    send(4'd0, 5'd9, 5'd10, 5'd11, 64'd0, 32'h8B0B0149, 1'b0, 1);   // ADD X9,X10,X11
    send(4'd4, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hF85F8041, 1'b0); // LDUR #-8
    send(4'd4, 5'd1, 5'd2, 5'd0, 64'h100, 32'h0, 1'b1);             // LDUR 256
    send(4'd7, 5'd3, 5'd0, 5'd0, 64'h0000_BEEF_0000_0000, 32'hD2D7DDE3, 1'b0);
    send(4'd7, 5'd3, 5'd0, 5'd0, 64'h10001, 32'h0, 1'b1);
    send(4'd6, 5'd5, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hB4FFFFE5, 1'b0);
    send(4'd6, 5'd5, 5'd0, 5'd0, 64'h40000, 32'h0, 1'b1);            // CBZ 2^18
    send(4'd6, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFC_0000, 32'hB4800000, 1'b0); // CBZ -2^18
    send(4'd5, 5'd3, 5'd4, 5'd0, 64'd255, 32'hF80FF083, 1'b0);      // STUR #255
    send(4'd4, 5'd3, 5'd4, 5'd0, 64'hFFFF_FFFF_FFFF_FEFF, 32'h0, 1'b1); // LDUR -257
    send(4'd1, 5'd1, 5'd2, 5'd3, 64'd0, 32'hCB030041, 1'b0);        // SUB
    send(4'd7, 5'd7, 5'd0, 5'd0, 64'd0, 32'hD2800007, 1'b0);        // MOVZ 0 -> hw 0
    send(4'd7, 5'd2, 5'd0, 5'd0, 64'hFFFF_0000_0000_0000, 32'hD2FFFFE2, 1'b0); // hw 3
    send(4'd9, 5'd1, 5'd1, 5'd1, 64'd0, 32'h0, 1'b1);               // illegal op
    drain();

    // Random traffic with random consumer stalls.
    rand_rdy = 1;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: begin t = longint'($urandom_range(0, 600)) - 300; imm = t; end
        1: begin
          t = longint'($urandom_range(0, 8)) - 4;
          t = t + (($urandom_range(0, 1) != 0) ? 262144 : -262144);
          imm = t;
        end
        2: imm = {48'd0, 16'($urandom)} << (16 * $urandom_range(0, 3));
        default: imm = {$urandom, $urandom};
      endcase
      send_m(4'($urandom_range(0, 9)), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end
    rand_rdy = 0;
    step();
    out_ready = 1'b1;
    drain();

    // Restart coinciding with a handshake.
    out_ready = 1'b0;
    send(4'd3, 5'd4, 5'd5, 5'd6, 64'd0, 32'hAA0600A4, 1'b0);        // ORR X4,X5,X6
    step();
    restart = 1'b1; out_ready = 1'b1;
    step();
    restart = 1'b0;
    @(negedge clk);
    chk("restart_addr", out_addr, BASE_A);
    step();

    // Six-word stream with a consumer stall.
    out_ready = 1'b0;
    r1 = model(4'd2, 5'd1, 5'd2, 5'd3, 64'd0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 64'd0, r1[31:0], r1[32]);
    send_m(4'd4, 5'd6, 5'd7, 5'd0, 64'd16);
    @(negedge clk);
    chk("stall_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_instr", out_instr, r1[31:0]);
      chk("stall_addr", out_addr, BASE_A);
      step();
      @(negedge clk);
    end
    step();
    out_ready = 1'b1;
    send_m(4'd7, 5'd8, 5'd0, 5'd0, 64'h0000_0000_1234_0000);
    send_m(4'd6, 5'd9, 5'd0, 5'd0, 64'd100);
    send_m(4'd0, 5'd10, 5'd11, 5'd12, 64'd0);
    send_m(4'd5, 5'd13, 5'd14, 5'd0, 64'hFFFF_FFFF_FFFF_FF00);
    drain();

    // Reset with both pipeline stages full.
    out_ready = 1'b0;
    send_m(4'd0, 5'd1, 5'd1, 5'd1, 64'd0);
    send_m(4'd4, 5'd2, 5'd2, 5'd0, 64'd999);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_addr", out_addr, BASE_A);
    chk("mid_rst_err_count", err_count, 8'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b1;
    send(4'd0, 5'd9, 5'd10, 5'd11, 64'd0, 32'h8B0B0149, 1'b0, 1);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
